// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply unit: FSM encoding, word stride, saturation bounds.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package matmul_pkg;

   // Sequencer states: one read of A, one read of B, one multiply-accumulate per k step,
   // then a single write of the finished C element.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      MAC  = 3'd3,
      WR   = 3'd4,
      DONE = 3'd5
   } matmulState_t;

   // Elements are 32-bit words, so consecutive elements are 4 bytes apart.
   localparam int unsigned WORD_STRIDE = 4;

   // Saturation bounds for an xlen-bit signed result, returned wide enough for any legal
   // xlen (up to 64), so callers can slice them down to their accumulator width.
   function automatic logic signed [127:0] satHi(input int unsigned xlen);
      return (128'sd1 <<< (xlen - 1)) - 128'sd1;
   endfunction

   function automatic logic signed [127:0] satLo(input int unsigned xlen);
      return -(128'sd1 <<< (xlen - 1));
   endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate for one C element; MATMUL_SAT_EN selects a saturating wide accumulator.
// Latency: accumulator updates on the clock edge ending an accEn cycle; result is combinational from it.
// Backpressure: none; the sequencer decides when to clear and when to accumulate.
module matmul_mac
   import matmul_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            accEn,
   input  logic [XLEN-1:0] opA,
   input  logic [XLEN-1:0] opB,
   output logic [XLEN-1:0] result
);

`ifdef MATMUL_SAT_EN
   localparam logic signed [127:0]        HI_WIDE = satHi(XLEN);
   localparam logic signed [127:0]        LO_WIDE = satLo(XLEN);
   localparam logic signed [2*XLEN-1:0]   SAT_HI  = HI_WIDE[2*XLEN-1:0];
   localparam logic signed [2*XLEN-1:0]   SAT_LO  = LO_WIDE[2*XLEN-1:0];

   logic signed [2*XLEN-1:0] acc;
   logic signed [2*XLEN-1:0] prod;

   // Sign-extend both operands so the low 2*XLEN bits of the product are the exact signed product.
   assign prod = {{XLEN{opA[XLEN-1]}}, opA} * {{XLEN{opB[XLEN-1]}}, opB};

   // Wide accumulator: cleared at launch and after each written element, summed on MAC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (accEn) begin
         acc <= acc + prod;
      end
   end

   // Clamp the wide sum into the signed XLEN range when it is handed to the write stage.
   always_comb begin
      result = acc[XLEN-1:0];
      if (acc > SAT_HI) begin
         result = SAT_HI[XLEN-1:0];
      end else if (acc < SAT_LO) begin
         result = SAT_LO[XLEN-1:0];
      end
   end
`else
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] prod;

   // Low XLEN bits of a product are the same for signed and unsigned operands, so this wraps correctly.
   assign prod = opA * opB;

   // Wrapping accumulator: cleared at launch and after each written element, summed on MAC cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (accEn) begin
         acc <= acc + prod;
      end
   end

   assign result = acc;
`endif

endmodule

// File: rtl/matmul_unit.sv
// Memory-mapped C = A x B sequencer (signed word elements, row-major); MATMUL_SAT_EN enables saturation.
// Latency: busy_o high for exactly 2 + N*N*(3N+1) cycles from the start_i cycle through the done_o cycle.
// Backpressure: none accepted (memory has no wait states); busy_o stalls the pipeline for the whole run.
module matmul_unit
   import matmul_pkg::*;
#(
   parameter int N    = 4,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic [XLEN-1:0] base_a_i,
   input  logic [XLEN-1:0] base_b_i,
   input  logic [XLEN-1:0] base_c_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   input  logic [XLEN-1:0] mem_rdata_i
);

   localparam int              IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0]   LAST = IW'(N - 1);
   localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

   matmulState_t    state;
   matmulState_t    stateNext;
   logic [XLEN-1:0] baseA;
   logic [XLEN-1:0] baseB;
   logic [XLEN-1:0] baseC;
   logic [XLEN-1:0] aReg;
   logic [XLEN-1:0] accResult;
   logic [IW-1:0]   rowIdx;
   logic [IW-1:0]   colIdx;
   logic [IW-1:0]   kIdx;
   logic            launch;
   logic            accClear;
   logic            accEn;

   // Byte address of element (row, col) in a row-major word matrix; wraps silently at XLEN bits.
   function automatic logic [XLEN-1:0] elemAddr(input logic [XLEN-1:0] base,
                                                input logic [IW-1:0]   row,
                                                input logic [IW-1:0]   col);
      logic [XLEN-1:0] idx;
      idx = XLEN'(row) * XLEN'(N) + XLEN'(col);
      return base + idx * XLEN'(WORD_STRIDE);
   endfunction

   assign launch   = (state == IDLE) && start_i;
   assign accClear = launch || (state == WR);
   assign accEn    = (state == MAC);

   // State register; reset parks the sequencer in IDLE, abandoning any run in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next state and memory/handshake outputs; reset overrides everything so no access leaks out.
   always_comb begin
      stateNext   = state;
      busy_o      = 1'b1;
      done_o      = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state)
         IDLE: begin
            busy_o = start_i;
            if (start_i) begin
               stateNext = RD_A;
            end
         end
         RD_A: begin
            mem_req_o  = 1'b1;
            mem_addr_o = elemAddr(baseA, rowIdx, kIdx);
            stateNext  = RD_B;
         end
         RD_B: begin
            mem_req_o  = 1'b1;
            mem_addr_o = elemAddr(baseB, kIdx, colIdx);
            stateNext  = MAC;
         end
         MAC: begin
            stateNext = (kIdx == LAST) ? WR : RD_A;
         end
         WR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = elemAddr(baseC, rowIdx, colIdx);
            mem_wdata_o = accResult;
            stateNext   = ((rowIdx == LAST) && (colIdx == LAST)) ? DONE : RD_A;
         end
         DONE: begin
            done_o    = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
      if (!rst_n) begin
         busy_o      = 1'b0;
         done_o      = 1'b0;
         mem_req_o   = 1'b0;
         mem_we_o    = 1'b0;
         mem_addr_o  = '0;
         mem_wdata_o = '0;
      end
   end

   // Operand bases, loop counters and the captured A element; bases are word-aligned at launch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baseA  <= '0;
         baseB  <= '0;
         baseC  <= '0;
         aReg   <= '0;
         rowIdx <= '0;
         colIdx <= '0;
         kIdx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  baseA  <= base_a_i & WORD_MASK;
                  baseB  <= base_b_i & WORD_MASK;
                  baseC  <= base_c_i & WORD_MASK;
                  rowIdx <= '0;
                  colIdx <= '0;
                  kIdx   <= '0;
               end
            end
            RD_B: begin
               aReg <= mem_rdata_i;
            end
            MAC: begin
               if (kIdx != LAST) begin
                  kIdx <= kIdx + 1'b1;
               end
            end
            WR: begin
               kIdx <= '0;
               if (colIdx == LAST) begin
                  colIdx <= '0;
                  rowIdx <= rowIdx + 1'b1;
               end else begin
                  colIdx <= colIdx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   matmul_mac #(
      .XLEN (XLEN)
   ) u_mac (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (accClear),
      .accEn  (accEn),
      .opA    (aReg),
      .opB    (mem_rdata_i),
      .result (accResult)
   );

endmodule

// File: tb/tb_matmul_unit.sv
// Self-checking bench for matmul_unit (N=2) with a zero-wait-state memory model and write scoreboard.
// Latency: checks the fixed busy window and single done pulse per run.
// Backpressure: n/a; the memory model always answers one cycle after a read.
module tb_matmul_unit;

   localparam int N    = 2;
   localparam int XLEN = 32;
   localparam int LAT  = 2 + N * N * (3 * N + 1);

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wrExp_t;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [31:0] base_a_i;
   logic [31:0] base_b_i;
   logic [31:0] base_c_i;
   logic        busy_o;
   logic        done_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   logic [31:0] mem [0:1023];
   wrExp_t      expQ[$];
   wrExp_t      monE;
   int          assertCount;
   int          failCount;
   int signed   matA[4];
   int signed   matB[4];

   matmul_unit #(
      .N    (N),
      .XLEN (XLEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .base_a_i    (base_a_i),
      .base_b_i    (base_b_i),
      .base_c_i    (base_c_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int wordIdx(input logic [31:0] addr);
      return int'(addr[11:2]);
   endfunction

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory model: reads return data the cycle after the request, writes land on the edge.
   always @(posedge clk) begin
      if (mem_req_o && mem_we_o) begin
         mem[wordIdx(mem_addr_o)] = mem_wdata_o;
      end else if (mem_req_o) begin
         mem_rdata_i <= mem[wordIdx(mem_addr_o)];
      end
   end

   // Access monitor: every access word-aligned, every write matched against the scoreboard.
   always @(negedge clk) begin
      if (mem_req_o) begin
         checkEq("addr_align", {30'd0, mem_addr_o[1:0]}, 32'd0);
      end
      if (mem_req_o && mem_we_o) begin
         if (expQ.size() == 0) begin
            checkEq("wr_unexpected", mem_addr_o, 32'hFFFF_FFFF);
         end else begin
            monE = expQ.pop_front();
            checkEq("wr_addr", mem_addr_o, monE.addr);
            checkEq("wr_data", mem_wdata_o, monE.data);
         end
      end
   end

   // Load A and B into memory and push the expected C writes in row-major order.
   task automatic prepare(input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc);
      logic [31:0] a0;
      logic [31:0] b0;
      logic [31:0] c0;
      longint      s;
      wrExp_t      e;
      a0 = ba & 32'hFFFF_FFFC;
      b0 = bb & 32'hFFFF_FFFC;
      c0 = bc & 32'hFFFF_FFFC;
      for (int x = 0; x < N * N; x++) begin
         mem[wordIdx(a0) + x] = matA[x];
         mem[wordIdx(b0) + x] = matB[x];
      end
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            s = 0;
            for (int q = 0; q < N; q++) begin
               s += longint'(matA[r * N + q]) * longint'(matB[q * N + c]);
            end
`ifdef MATMUL_SAT_EN
            if (s > 64'sh7FFF_FFFF) begin
               s = 64'sh7FFF_FFFF;
            end else if (s < -64'sh8000_0000) begin
               s = -64'sh8000_0000;
            end
`endif
            e.addr = c0 + 32'(4 * (r * N + c));
            e.data = s[31:0];
            expQ.push_back(e);
         end
      end
   endtask

   // Launch one run; optionally re-pulse start_i or assert reset at a given cycle of the run.
   task automatic runOp(input logic [31:0] ba, input logic [31:0] bb, input logic [31:0] bc,
                        input int restartAt, input int resetAt);
      int busyCyc;
      int doneCnt;
      bit resetHit;
      busyCyc  = 0;
      doneCnt  = 0;
      resetHit = 0;
      @(posedge clk);
      #1;
      base_a_i = ba;
      base_b_i = bb;
      base_c_i = bc;
      start_i  = 1'b1;
      for (int cyc = 0; cyc < LAT + 20; cyc++) begin
         @(negedge clk);
         if (cyc == resetAt) begin
            checkEq("rst_mid_busy", 32'(busy_o), 32'd0);
            checkEq("rst_mid_req", 32'(mem_req_o), 32'd0);
            checkEq("rst_mid_we", 32'(mem_we_o), 32'd0);
            checkEq("rst_mid_done", 32'(done_o), 32'd0);
            resetHit = 1;
            break;
         end
         if (busy_o) busyCyc++;
         if (done_o) begin
            doneCnt++;
            break;
         end
         @(posedge clk);
         #1;
         start_i = (cyc + 1 == restartAt);
         if (cyc + 1 == restartAt) begin
            base_a_i = 32'hA00;
            base_b_i = 32'hA40;
            base_c_i = 32'hA80;
         end
         if (cyc + 1 == resetAt) rst_n = 1'b0;
      end
      if (!resetHit) begin
         @(negedge clk);
         if (done_o) doneCnt++;
         checkEq("busy_after_done", 32'(busy_o), 32'd0);
         checkEq("busy_cycles", busyCyc, LAT);
         checkEq("done_pulses", doneCnt, 32'd1);
         checkEq("writes_pending", expQ.size(), 32'd0);
      end
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst_n       = 1'b0;
      start_i     = 1'b1;
      base_a_i    = 32'h103;
      base_b_i    = 32'h201;
      base_c_i    = 32'h300;
      mem_rdata_i = '0;
      for (int x = 0; x < 1024; x++) mem[x] = '0;

      // Reset state, with start_i held high throughout.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkEq("rst_busy", 32'(busy_o), 32'd0);
      checkEq("rst_done", 32'(done_o), 32'd0);
      checkEq("rst_req", 32'(mem_req_o), 32'd0);
      checkEq("rst_we", 32'(mem_we_o), 32'd0);
      checkEq("rst_addr", mem_addr_o, 32'd0);
      checkEq("rst_wdata", mem_wdata_o, 32'd0);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      rst_n   = 1'b1;

      // Basic positive product.
      matA = '{1, 2, 3, 4};
      matB = '{5, 6, 7, 8};
      prepare(32'h100, 32'h200, 32'h300);
      runOp(32'h100, 32'h200, 32'h300, -1, -1);
      checkEq("basic_c00", mem[wordIdx(32'h300)], 32'd19);
      checkEq("basic_c11", mem[wordIdx(32'h30C)], 32'd50);

      // Negative operands.
      matA = '{-1, 0, 0, -1};
      matB = '{-3, 4, 5, -6};
      prepare(32'h400, 32'h500, 32'h600);
      runOp(32'h400, 32'h500, 32'h600, -1, -1);
      checkEq("neg_c01", mem[wordIdx(32'h604)], 32'hFFFF_FFFC);
      checkEq("neg_c10", mem[wordIdx(32'h608)], 32'hFFFF_FFFB);

      // Overflow of the accumulated sum.
      matA = '{32'h4000_0000, 32'h4000_0000, 1, -1};
      matB = '{2, 3, 2, 4};
      prepare(32'h700, 32'h780, 32'h800);
      runOp(32'h700, 32'h780, 32'h800, -1, -1);
`ifdef MATMUL_SAT_EN
      checkEq("ovf_c00", mem[wordIdx(32'h800)], 32'h7FFF_FFFF);
`else
      checkEq("ovf_c00", mem[wordIdx(32'h800)], 32'h0000_0000);
`endif

      // Second start pulse mid-run with other bases must be ignored.
      matA = '{1, 2, 3, 4};
      matB = '{5, 6, 7, 8};
      prepare(32'h100, 32'h200, 32'h900);
      runOp(32'h100, 32'h200, 32'h900, 5, -1);
      checkEq("restart_c10", mem[wordIdx(32'h908)], 32'd43);

      // Reset in cycle 10 abandons the run; nothing written afterwards.
      prepare(32'h100, 32'h200, 32'hB00);
      mem[wordIdx(32'hB04)] = 32'h5A5A_5A5A;
      runOp(32'h100, 32'h200, 32'hB00, -1, 10);
      expQ.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkEq("rst_hold_req", 32'(mem_req_o), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkEq("no_wr_after_rst", mem[wordIdx(32'hB04)], 32'h5A5A_5A5A);
      prepare(32'h100, 32'h200, 32'hB40);
      runOp(32'h100, 32'h200, 32'hB40, -1, -1);
      checkEq("after_rst_c11", mem[wordIdx(32'hB4C)], 32'd50);

      // Unaligned bases are forced to word alignment.
      matA = '{2, 0, 0, 2};
      matB = '{1, 2, 3, 4};
      prepare(32'h103, 32'h201, 32'h302);
      runOp(32'h103, 32'h201, 32'h302, -1, -1);
      checkEq("align_c11", mem[wordIdx(32'h30C)], 32'd8);

      // start_i while reset is held must not raise busy_o.
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      checkEq("rst_start_busy", 32'(busy_o), 32'd0);
      checkEq("rst_start_req", 32'(mem_req_o), 32'd0);
      @(posedge clk);
      #1;
      start_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/matmul_unit.md
MATMUL_UNIT -- requirements
Module: matmul_unit

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (legal 2..8).
REQ-002 SHALL have parameter XLEN, default 32, element and address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  one-cycle launch pulse from the Execute stage.
REQ-006 SHALL have ports base_a_i / base_b_i / base_c_i  input  XLEN each  byte base addresses of A, B, C (row-major, word elements).
REQ-007 SHALL have port busy_o  output  1  stall request, wired to the hazard unit MatmulBusy input.
REQ-008 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports mem_req_o  output  1; mem_we_o  output  1; mem_addr_o  output  XLEN; mem_wdata_o  output  XLEN  data-memory master port.
REQ-010 SHALL have port mem_rdata_i  input  XLEN  read data, valid exactly one cycle after a read request; the port has no wait states.

Function
REQ-011 SHALL compute C = A x B with signed two's-complement elements.
REQ-012 SHALL implement FSM states IDLE, RD_A, RD_B, MAC, WR, DONE.
REQ-013 IDLE: on start_i, latch bases with bits [1:0] forced to 0, clear i, j, k and accumulator, go to RD_A; start_i outside IDLE SHALL be ignored.
REQ-014 RD_A: mem_req_o=1, mem_we_o=0, mem_addr_o = baseA + 4*(i*N+k); go to RD_B.
REQ-015 RD_B: capture mem_rdata_i as a; issue a read at baseB + 4*(k*N+j); go to MAC.
REQ-016 MAC: acc += a * mem_rdata_i; if k==N-1 go to WR, else increment k and go to RD_A.
REQ-017 WR: mem_req_o=1, mem_we_o=1, mem_addr_o = baseC + 4*(i*N+j), mem_wdata_o = result; clear acc and k; advance j, with i incrementing on j wrap; after the last element go to DONE, else go to RD_A.
REQ-018 DONE: done_o=1 for exactly this cycle; return to IDLE.
REQ-019 busy_o SHALL equal start_i in IDLE, and 1 in all other states, so the launch cycle already stalls Fetch/Decode.
REQ-020 Latency SHALL be fixed: busy_o high for 2 + N*N*(3N+1) cycles (N=2: 30; N=4: 210).
REQ-021 mem_req_o SHALL be 0 in IDLE and DONE; mem_we_o SHALL be 1 only in WR.
REQ-022 Products and the accumulator SHALL wrap modulo 2^XLEN unless REQ-027 applies.
REQ-023 Address arithmetic SHALL wrap modulo 2^XLEN without error indication.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, and force busy_o, done_o, mem_req_o and mem_we_o to 0, independent of start_i.
REQ-025 rst_n low SHALL clear mem_addr_o, mem_wdata_o, the counters and the accumulator to 0.
REQ-026 A reset mid-operation SHALL abandon the operation with no further memory writes; C is left partially written.

Configuration
REQ-027 With MATMUL_SAT_EN defined, the unit SHALL accumulate in a 2*XLEN signed register and clamp to [-2^(XLEN-1), 2^(XLEN-1)-1] at WR; without it, the unit SHALL use an XLEN-bit wrapping accumulator. Latency SHALL be identical in both builds.

Structure
REQ-028 Package matmul_pkg SHALL hold the state encoding, the word stride (4) and the saturation bounds.
REQ-029 Multiply, accumulate and saturate SHALL reside in sub-module matmul_mac; matmul_unit SHALL hold the FSM, counters and memory port.

Verification
REQ-030 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]], busy_o high 30 cycles, single done_o pulse.
REQ-031 N=2, A=[[-1,0],[0,-1]], B=[[-3,4],[5,-6]] -> C=[[3,-4],[-5,6]].
REQ-032 N=2, A row0=[0x40000000,0x40000000], B col0=[2,2] -> C[0][0]=0x7FFFFFFF with MATMUL_SAT_EN, 0x00000000 without.
REQ-033 start_i pulsed again in cycle 5 with different bases -> ignored, original result and latency unchanged.
REQ-034 rst_n low in cycle 10 -> busy_o and mem_req_o low in the same cycle, no writes afterwards; a new start_i after release completes REQ-030 correctly.
REQ-035 Base addresses 0x103 and 0x201 -> all accesses at 0x100 and 0x200 offsets; start_i with rst_n low -> busy_o stays 0.
